// File: rtl/mdu_if.sv
// Operand/opcode bus between the E stage and the multiply/divide unit.
// Handshake: start is the accept strobe; an op in 1..4 is accepted only on a cycle with busy=0, otherwise dropped.
interface mdu_if;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  mdu_op;
  logic        busy;
  logic        start;
  logic [31:0] result;

  modport master (
    output in_a, in_b, mdu_op,
    input  busy, start, result
  );

  modport slave (
    input  in_a, in_b, mdu_op,
    output busy, start, result
  );
endinterface

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide unit: fixed-latency busy window, owns HI/LO.
// Result is computed at accept into pend regs and committed on the last busy edge.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus,
   output logic state_dbg
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   state_t      state;
   logic [3:0]  cnt, cnt_nx;
   logic [31:0] hi, hi_nx, lo, lo_nx;
   logic [31:0] pend_hi, pend_hi_nx, pend_lo, pend_lo_nx;

   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, dvd, dvs, uq, ur, sq, sr;
   logic        is_start;

   assign state     = (cnt != 4'd0) ? BUSY : IDLE;
   assign state_dbg = state;
   assign bus.busy  = (state == BUSY);
   assign bus.start = is_start;

   assign is_start = (bus.mdu_op >= OP_MULT) && (bus.mdu_op <= OP_DIVU) && (state == IDLE);

   // Low 64 bits of the product of sign-extended operands is the signed product.
   assign prod_s = {{32{bus.in_a[31]}}, bus.in_a} * {{32{bus.in_b[31]}}, bus.in_b};
   assign prod_u = {32'd0, bus.in_a} * {32'd0, bus.in_b};

   // One unsigned divider serves both div flavours; signed operands go in as magnitudes.
   assign abs_a = bus.in_a[31] ? (32'd0 - bus.in_a) : bus.in_a;
   assign abs_b = bus.in_b[31] ? (32'd0 - bus.in_b) : bus.in_b;
   assign dvd   = (bus.mdu_op == OP_DIV) ? abs_a : bus.in_a;
   assign dvs   = (bus.in_b == 32'd0) ? 32'd1 : ((bus.mdu_op == OP_DIV) ? abs_b : bus.in_b);
   assign uq    = dvd / dvs;
   assign ur    = dvd % dvs;
   assign sq    = (bus.in_a[31] ^ bus.in_b[31]) ? (32'd0 - uq) : uq;
   assign sr    = bus.in_a[31] ? (32'd0 - ur) : ur;

   always_comb begin
      cnt_nx     = cnt;
      hi_nx      = hi;
      lo_nx      = lo;
      pend_hi_nx = pend_hi;
      pend_lo_nx = pend_lo;
      case (state)
         IDLE: begin
            if (is_start) begin
               case (bus.mdu_op)
                  OP_MULT:  {pend_hi_nx, pend_lo_nx} = prod_s;
                  OP_MULTU: {pend_hi_nx, pend_lo_nx} = prod_u;
                  OP_DIV:   {pend_hi_nx, pend_lo_nx} = (bus.in_b == 32'd0) ? {hi, lo} : {sr, sq};
                  default:  {pend_hi_nx, pend_lo_nx} = (bus.in_b == 32'd0) ? {hi, lo} : {ur, uq};
               endcase
               cnt_nx = (bus.mdu_op <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end else if (bus.mdu_op == OP_MTHI) begin
               hi_nx = bus.in_a;
            end else if (bus.mdu_op == OP_MTLO) begin
               lo_nx = bus.in_a;
            end
         end
         BUSY: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               hi_nx = pend_hi;
               lo_nx = pend_lo;
            end
         end
         default: cnt_nx = 4'd0;
      endcase
   end

   always_comb begin
      bus.result = 32'd0;
      if (bus.mdu_op == OP_MFHI)      bus.result = hi;
      else if (bus.mdu_op == OP_MFLO) bus.result = lo;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= 4'd0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
      end else begin
         cnt     <= cnt_nx;
         hi      <= hi_nx;
         lo      <= lo_nx;
         pend_hi <= pend_hi_nx;
         pend_lo <= pend_lo_nx;
      end
   end
endmodule
